// File: rtl/async_operator_buffered.sv
// async_operator_buffered
//   Dataflow node: joins INPUT_SIZE pull-style operand channels, applies OP,
//   queues results in a DEPTH-entry FIFO and forks each result eagerly to
//   OUTPUT_SIZE consumers. Each consumer is acknowledged once per entry, and
//   consumers may be acknowledged on different cycles.
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_l      per-operand request to the upstream producer
//   ack_l      per-operand 1-cycle ack; the matching din slice is valid that cycle
//   din        operands, slice i = din[DATA_WIDTH*i +: DATA_WIDTH]
//   req_r      per-consumer request
//   ack_r      per-consumer 1-cycle ack; dout is valid that cycle
//   dout       registered head-of-FIFO result
//   occupancy  number of FIFO entries held
//   fire_count results produced since reset (wraps)
module async_operator_buffered #(
  parameter int    DATA_WIDTH  = 32,
  parameter string OP          = "reg",
  parameter int    IMMEDIATE   = 0,
  parameter int    INPUT_SIZE  = 1,
  parameter int    OUTPUT_SIZE = 1,
  parameter int    DEPTH       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy,
  output logic [31:0]                      fire_count
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] OP_REG  = 4'd0;
  localparam logic [3:0] OP_IN   = 4'd1;
  localparam logic [3:0] OP_OUT  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_SUBI = 4'd7;
  localparam logic [3:0] OP_MULI = 4'd8;
  localparam logic [3:0] OP_BAD  = 4'd15;

  localparam logic [3:0] OP_SEL =
    (OP == "reg")  ? OP_REG  : (OP == "in")   ? OP_IN   :
    (OP == "out")  ? OP_OUT  : (OP == "add")  ? OP_ADD  :
    (OP == "sub")  ? OP_SUB  : (OP == "mul")  ? OP_MUL  :
    (OP == "addi") ? OP_ADDI : (OP == "subi") ? OP_SUBI :
    (OP == "muli") ? OP_MULI : OP_BAD;

  localparam bit OP_BINARY = (OP_SEL == OP_ADD) || (OP_SEL == OP_SUB) || (OP_SEL == OP_MUL);
  localparam bit SIZE_OK   = OP_BINARY ? (INPUT_SIZE >= 2 && INPUT_SIZE <= 3) : (INPUT_SIZE == 1);
  localparam logic [DATA_WIDTH-1:0] IMM = DATA_WIDTH'(IMMEDIATE);
  localparam int N_OPND = (INPUT_SIZE < 3) ? INPUT_SIZE : 3;

  if (OP_SEL == OP_BAD || !SIZE_OK || OUTPUT_SIZE < 1 || DEPTH < 1) begin : g_illegal
    $error("async_operator_buffered: illegal OP/INPUT_SIZE/OUTPUT_SIZE/DEPTH combination");
  end

  // Operand side state
  logic [DATA_WIDTH-1:0]  slot_q [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]  slot_d [INPUT_SIZE];
  logic [INPUT_SIZE-1:0]  full_q, full_d;
  logic [INPUT_SIZE-1:0]  req_l_q, req_l_d;

  // Result FIFO and fork state
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occupancy_q, occupancy_d;
  logic [OUTPUT_SIZE-1:0] served_q, served_d;
  logic [OUTPUT_SIZE-1:0] ack_r_q, ack_r_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic [31:0]            fire_count_q, fire_count_d;

  logic [DATA_WIDTH-1:0]  opnd_s [3];
  logic [DATA_WIDTH-1:0]  result_s;
  logic                   fire_s, pop_s;

  // Operand view: absent third operand is the identity of the operation
  always_comb begin
    opnd_s[0] = '0;
    opnd_s[1] = '0;
    opnd_s[2] = (OP_SEL == OP_MUL) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : '0;
    for (int i = 0; i < N_OPND; i++) begin
      opnd_s[i] = slot_q[i];
    end
  end

  // Operator datapath, modulo 2^DATA_WIDTH
  always_comb begin
    case (OP_SEL)
      OP_ADD:  result_s = opnd_s[0] + opnd_s[1] + opnd_s[2];
      OP_SUB:  result_s = opnd_s[0] - opnd_s[1] - opnd_s[2];
      OP_MUL:  result_s = opnd_s[0] * opnd_s[1] * opnd_s[2];
      OP_ADDI: result_s = opnd_s[0] + IMM;
      OP_SUBI: result_s = opnd_s[0] - IMM;
      OP_MULI: result_s = opnd_s[0] * IMM;
      default: result_s = opnd_s[0];
    endcase
  end

  // Fork: ack each requesting, not-yet-served consumer; pop once all are served
  always_comb begin
    ack_r_d  = (occupancy_q != '0) ? (req_r & ~served_q & ~ack_r_q) : '0;
    pop_s    = (|ack_r_d) && (&(served_q | ack_r_d));
    served_d = pop_s ? '0 : (served_q | ack_r_d);
    dout_d   = (|ack_r_d) ? mem_q[rd_ptr_q] : dout_q;
    // A pop on the same edge frees the slot the fire needs
    fire_s   = (&full_q) && ((occupancy_q < OCC_W'(DEPTH)) || pop_s);
  end

  // FIFO pointer, occupancy and fire counter bookkeeping
  always_comb begin
    if (fire_s) begin
      wr_ptr_d     = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      fire_count_d = fire_count_q + 32'd1;
    end else begin
      wr_ptr_d     = wr_ptr_q;
      fire_count_d = fire_count_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({fire_s, pop_s})
      2'b10:   occupancy_d = occupancy_q + OCC_W'(1);
      2'b01:   occupancy_d = occupancy_q - OCC_W'(1);
      default: occupancy_d = occupancy_q;
    endcase
  end

  // Join: request empty slots, capture on ack, clear every slot on fire
  always_comb begin
    slot_d  = slot_q;
    full_d  = full_q;
    req_l_d = req_l_q;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (fire_s) begin
        slot_d[i]  = '0;
        full_d[i]  = 1'b0;
        req_l_d[i] = 1'b0;
      end else if (!full_q[i] && ack_l[i]) begin
        slot_d[i]  = din[DATA_WIDTH*i +: DATA_WIDTH];
        full_d[i]  = 1'b1;
        req_l_d[i] = 1'b0;
      end else if (!full_q[i] && !req_l_q[i]) begin
        req_l_d[i] = 1'b1;
      end else begin
        req_l_d[i] = req_l_q[i];
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        slot_q[i] <= '0;
      end
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      full_q       <= '0;
      req_l_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occupancy_q  <= '0;
      served_q     <= '0;
      ack_r_q      <= '0;
      dout_q       <= '0;
      fire_count_q <= 32'd0;
    end else begin
      slot_q       <= slot_d;
      full_q       <= full_d;
      req_l_q      <= req_l_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occupancy_q  <= occupancy_d;
      served_q     <= served_d;
      ack_r_q      <= ack_r_d;
      dout_q       <= dout_d;
      fire_count_q <= fire_count_d;
      if (fire_s) begin
        mem_q[wr_ptr_q] <= result_s;
      end else begin
        mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
    end
  end

  assign req_l      = req_l_q;
  assign ack_r      = ack_r_q;
  assign dout       = dout_q;
  assign occupancy  = occupancy_q;
  assign fire_count = fire_count_q;

endmodule

// File: tb/tb_async_operator_buffered.sv
// Scoreboard bench for async_operator_buffered.
//   u_add : OP=add,  IN=2, OUT=1, DEPTH=2, 32-bit
//   u_addi: OP=addi, IMMEDIATE=2, IN=1, OUT=3, DEPTH=2, 8-bit
module tb_async_operator_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]  req_l_a, ack_l_a;
  logic [63:0] din_a;
  logic [0:0]  req_r_a, ack_r_a;
  logic [31:0] dout_a, fc_a;
  logic [1:0]  occ_a;

  logic [0:0]  req_l_b, ack_l_b;
  logic [7:0]  din_b, dout_b;
  logic [2:0]  req_r_b, ack_r_b;
  logic [1:0]  occ_b;
  logic [31:0] fc_b;

  async_operator_buffered #(.DATA_WIDTH(32), .OP("add"), .IMMEDIATE(0),
    .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(2)) u_add (
    .clk(clk), .rst(rst_n), .req_l(req_l_a), .ack_l(ack_l_a), .din(din_a),
    .req_r(req_r_a), .ack_r(ack_r_a), .dout(dout_a), .occupancy(occ_a),
    .fire_count(fc_a));

  async_operator_buffered #(.DATA_WIDTH(8), .OP("addi"), .IMMEDIATE(2),
    .INPUT_SIZE(1), .OUTPUT_SIZE(3), .DEPTH(2)) u_addi (
    .clk(clk), .rst(rst_n), .req_l(req_l_b), .ack_l(ack_l_b), .din(din_b),
    .req_r(req_r_b), .ack_r(ack_r_b), .dout(dout_b), .occupancy(occ_b),
    .fire_count(fc_b));

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] q_a[$];
  logic [7:0]  q_b[$];
  int cnt_b[3];
  int pairs_a = 0;
  logic prev_ack_a = 1'b0;
  logic [2:0] prev_ack_b = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor for u_add: sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (ack_r_a[0]) begin
        if (q_a.size() == 0) chk("a_extra_ack", 32'd1, 32'd0);
        else chk("a_dout", dout_a, q_a.pop_front());
      end
      if (ack_r_a[0] && prev_ack_a) chk("a_ack_back_to_back", 32'd1, 32'd0);
      prev_ack_a = ack_r_a[0];
      for (int j = 0; j < 3; j++) begin
        if (ack_r_b[j]) begin
          if (cnt_b[j] >= q_b.size()) chk("b_extra_ack", 32'd1, 32'd0);
          else chk("b_dout", {24'd0, dout_b}, {24'd0, q_b[cnt_b[j]]});
          cnt_b[j]++;
        end
        if (ack_r_b[j] && prev_ack_b[j]) chk("b_ack_back_to_back", 32'd1, 32'd0);
      end
      prev_ack_b = ack_r_b;
    end else begin
      prev_ack_a = 1'b0;
      prev_ack_b = 3'b000;
    end
  end

  task automatic send_a(input int idx, input logic [31:0] val);
    int k = 0;
    while (!req_l_a[idx] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("a_req_l_wait", {31'd0, req_l_a[idx]}, 32'd1);
    ack_l_a[idx] = 1'b1;
    din_a[idx*32 +: 32] = val;
    @(negedge clk);
    ack_l_a[idx] = 1'b0;
  endtask

  task automatic send_pair_a(input logic [31:0] a, input logic [31:0] b);
    send_a(0, a);
    send_a(1, b);
    q_a.push_back(a + b);
    pairs_a++;
  endtask

  task automatic send_b(input logic [7:0] val);
    int k = 0;
    while (!req_l_b[0] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("b_req_l_wait", {31'd0, req_l_b[0]}, 32'd1);
    ack_l_b[0] = 1'b1;
    din_b = val;
    q_b.push_back(val + 8'd2);
    @(negedge clk);
    ack_l_b[0] = 1'b0;
  endtask

  task automatic drain_a();
    int k = 0;
    while ((q_a.size() != 0 || occ_a != 2'd0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("a_drain", {31'd0, (q_a.size() == 0)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    ack_l_a = 2'b00; din_a = 64'd0; req_r_a = 1'b0;
    ack_l_b = 1'b0;  din_b = 8'd0;  req_r_b = 3'b000;
    for (int j = 0; j < 3; j++) cnt_b[j] = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_l", {30'd0, req_l_a}, 32'd0);
    chk("rst_ack_r", {31'd0, ack_r_a}, 32'd0);
    chk("rst_dout", dout_a, 32'd0);
    chk("rst_occ", {30'd0, occ_a}, 32'd0);
    chk("rst_fire_count", fc_a, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_l_after_rst", {30'd0, req_l_a}, 32'd3);

    // Basic add: 5 + 7
    req_r_a = 1'b1;
    send_a(0, 32'd5);
    send_a(1, 32'd7);
    q_a.push_back(32'd12);
    pairs_a++;
    drain_a();
    chk("t1_fire_count", fc_a, 32'd1);
    repeat (2) @(negedge clk);
    chk("t1_req_l_rearm", {30'd0, req_l_a}, 32'd3);

    // Back-pressure: fill FIFO with 1,2 and park 3 in the operand slots
    req_r_a = 1'b0;
    send_pair_a(32'd1, 32'd0);
    send_pair_a(32'd2, 32'd0);
    send_pair_a(32'd3, 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_occ_full", {30'd0, occ_a}, 32'd2);
    chk("t3_req_l_held", {30'd0, req_l_a}, 32'd0);
    chk("t3_fire_count", fc_a, pairs_a - 1);
    // Release: first pop and the parked fire share one edge at occupancy=DEPTH
    req_r_a = 1'b1;
    @(negedge clk);
    chk("t5_ack", {31'd0, ack_r_a}, 32'd1);
    chk("t5_occ_stays_full", {30'd0, occ_a}, 32'd2);
    chk("t5_fire_count", fc_a, pairs_a);
    drain_a();

    // Mid-stream asynchronous reset
    req_r_a = 1'b0;
    send_pair_a(32'd9, 32'd9);
    send_pair_a(32'd8, 32'd8);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ack_r", {31'd0, ack_r_a}, 32'd0);
    chk("t6_req_l", {30'd0, req_l_a}, 32'd0);
    chk("t6_occ", {30'd0, occ_a}, 32'd0);
    chk("t6_fire_count", fc_a, 32'd0);
    chk("t6_dout", dout_a, 32'd0);
    q_a.delete();
    pairs_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    req_r_a = 1'b1;
    send_pair_a(32'd40, 32'd2);
    drain_a();
    chk("t6_fire_after", fc_a, 32'd1);

    // addi wrap-around, all three consumers requesting together
    req_r_b = 3'b111;
    send_b(8'hFF);
    begin
      int k = 0;
      while ((cnt_b[2] < 1 || occ_b != 2'd0) && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t2_acks", cnt_b[0] + cnt_b[1] + cnt_b[2], 32'd3);
    chk("t2_fire_count", fc_b, 32'd1);

    // Staggered consumers: requests at cycles 0, 4, 9
    req_r_b = 3'b000;
    send_b(8'h10);
    begin
      int k = 0;
      while (occ_b != 2'd1 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t4_occ_one", {30'd0, occ_b}, 32'd1);
    for (int c = 0; c < 14; c++) begin
      if (c == 0) req_r_b[0] = 1'b1;
      if (c == 4) req_r_b[1] = 1'b1;
      if (c == 9) begin
        chk("t4_no_early_pop", {30'd0, occ_b}, 32'd1);
        chk("t4_c0_once", cnt_b[0], 32'd2);
        chk("t4_c1_once", cnt_b[1], 32'd2);
        req_r_b[2] = 1'b1;
      end
      @(negedge clk);
    end
    chk("t4_popped", {30'd0, occ_b}, 32'd0);
    chk("t4_c0_total", cnt_b[0], 32'd2);
    chk("t4_c2_total", cnt_b[2], 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
